// File: rtl/fsm_pkg.sv
// Shared definitions for the fsm transition-table path: stream magic, W0 field
// offsets, loader state encoding and rejection codes.
package fsm_pkg;

  localparam logic [7:0] CFG_MAGIC   = 8'hA5;
  localparam int         W0_SRC_LSB  = 0;
  localparam int         W0_NEXT_LSB = 16;

  typedef enum logic [2:0] {
    ERR_NONE               = 3'd0,
    ERR_BAD_MAGIC          = 3'd1,
    ERR_BAD_COUNT          = 3'd2,
    ERR_BAD_INDEX          = 3'd3,
    ERR_VALUE_OUTSIDE_MASK = 3'd4,
    ERR_EARLY_LAST         = 3'd5,
    ERR_MISSING_LAST       = 3'd6
  } err_code_e;

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_ADDR   = 3'd1,
    S_MASK   = 3'd2,
    S_VALUE  = 3'd3,
    S_WRITE  = 3'd4,
    S_COMMIT = 3'd5,
    S_DRAIN  = 3'd6,
    S_ERR    = 3'd7
  } ld_state_e;

endpackage

// File: rtl/fsm_table_loader.sv
// Parses a table image from a valid/ready word stream, writes entries into the
// fsm staging table and pulses tbl_commit only for a complete, clean image.
//
// state  | meaning
// HDR    | wait for header word (magic + entry count)
// ADDR   | wait for W0 (src / next)
// MASK   | wait for W1 (care mask)
// VALUE  | wait for W2 (value under mask)
// WRITE  | one-cycle staging write, decide next entry / commit / error
// COMMIT | one-cycle commit pulse
// DRAIN  | discard words of a rejected image up to cfg_last
// ERR    | one-cycle err pulse with err_code
module fsm_table_loader
  import fsm_pkg::*;
#(
  parameter int INPUTS  = 8,
  parameter int STATES  = 8,
  parameter int STWIDTH = $clog2(STATES),
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DATA_W-1:0]  cfg_data,
  input  logic               cfg_last,
  output logic               tbl_we,
  output logic [STWIDTH-1:0] tbl_addr,
  output logic [INPUTS-1:0]  tbl_mask,
  output logic [INPUTS-1:0]  tbl_value,
  output logic [STWIDTH-1:0] tbl_next,
  output logic               tbl_commit,
  output logic               busy,
  output logic               err,
  output logic [2:0]         err_code
);

  localparam logic [15:0]      MAX_N   = 16'(STATES);
  localparam logic [STWIDTH:0] N_STATE = (STWIDTH+1)'(STATES);

  ld_state_e          state_q, state_d;
  err_code_e          pend_q, code_q, fail_code;
  logic               fail, accept, rdy, last_q;
  logic [STWIDTH:0]   n_q, cnt_q, cnt_inc, src_w, nxt_w;
  logic [STWIDTH-1:0] addr_q, next_q;
  logic [INPUTS-1:0]  mask_q, value_q;
  logic [15:0]        hdr_n;
  logic               unused_bits;

  assign hdr_n       = cfg_data[15:0];
  assign src_w       = {1'b0, cfg_data[W0_SRC_LSB +: STWIDTH]};
  assign nxt_w       = {1'b0, cfg_data[W0_NEXT_LSB +: STWIDTH]};
  assign cnt_inc     = cnt_q + 1'b1;
  assign cfg_ready   = rdy & rst;
  assign accept      = cfg_valid & cfg_ready;
  assign unused_bits = ^cfg_data;

  always_comb begin
    state_d   = state_q;
    fail      = 1'b0;
    fail_code = ERR_NONE;
    rdy       = 1'b0;
    case (state_q)
      S_HDR: begin
        rdy = 1'b1;
        if (accept) begin
          if (cfg_data[31:24] != CFG_MAGIC) begin
            fail = 1'b1; fail_code = ERR_BAD_MAGIC;
          end else if (hdr_n == 16'd0 || hdr_n > MAX_N) begin
            fail = 1'b1; fail_code = ERR_BAD_COUNT;
          end else if (cfg_last) begin
            fail = 1'b1; fail_code = ERR_EARLY_LAST;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        rdy = 1'b1;
        if (accept) begin
          if (src_w >= N_STATE || nxt_w >= N_STATE) begin
            fail = 1'b1; fail_code = ERR_BAD_INDEX;
          end else if (cfg_last) begin
            fail = 1'b1; fail_code = ERR_EARLY_LAST;
          end else begin
            state_d = S_MASK;
          end
        end
      end
      S_MASK: begin
        rdy = 1'b1;
        if (accept) begin
          if (cfg_last) begin
            fail = 1'b1; fail_code = ERR_EARLY_LAST;
          end else begin
            state_d = S_VALUE;
          end
        end
      end
      S_VALUE: begin
        rdy = 1'b1;
        if (accept) begin
          if ((cfg_data[INPUTS-1:0] & ~mask_q) != '0) begin
            fail = 1'b1; fail_code = ERR_VALUE_OUTSIDE_MASK;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (cnt_inc == n_q) begin
          if (last_q) state_d = S_COMMIT;
          else begin
            fail = 1'b1; fail_code = ERR_MISSING_LAST;
          end
        end else if (last_q) begin
          fail = 1'b1; fail_code = ERR_EARLY_LAST;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_COMMIT: state_d = S_HDR;
      S_DRAIN: begin
        rdy = 1'b1;
        if (accept && cfg_last) state_d = S_ERR;
      end
      S_ERR:    state_d = S_HDR;
      default:  state_d = S_HDR;
    endcase
    // Once the image's last word is consumed there is nothing left to drain.
    if (fail) state_d = ((accept && cfg_last) || last_q) ? S_ERR : S_DRAIN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_HDR;
      pend_q  <= ERR_NONE;
      code_q  <= ERR_NONE;
      last_q  <= 1'b0;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      next_q  <= '0;
      mask_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      if (fail) pend_q <= fail_code;
      // err_code only changes as err is raised, so it holds between pulses.
      if (state_d == S_ERR && state_q != S_ERR) code_q <= fail ? fail_code : pend_q;
      if (state_d == S_HDR) last_q <= 1'b0;
      else if (accept && cfg_last) last_q <= 1'b1;
      if (accept) begin
        case (state_q)
          S_HDR: begin
            n_q   <= hdr_n[STWIDTH:0];
            cnt_q <= '0;
          end
          S_ADDR: begin
            addr_q <= cfg_data[W0_SRC_LSB +: STWIDTH];
            next_q <= cfg_data[W0_NEXT_LSB +: STWIDTH];
          end
          S_MASK:  mask_q  <= cfg_data[INPUTS-1:0];
          S_VALUE: value_q <= cfg_data[INPUTS-1:0];
          default: ;
        endcase
      end
      if (state_q == S_WRITE) cnt_q <= cnt_inc;
    end
  end

  assign tbl_we     = (state_q == S_WRITE);
  assign tbl_commit = (state_q == S_COMMIT);
  assign err        = (state_q == S_ERR);
  assign busy       = (state_q != S_HDR);
  assign tbl_addr   = addr_q;
  assign tbl_next   = next_q;
  assign tbl_mask   = mask_q;
  assign tbl_value  = value_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_fsm_table_loader.sv
// Scoreboard bench for fsm_table_loader: a word-level image parser predicts the
// write/commit/err events, a monitor process pops and compares them.
module tb_fsm_table_loader;

  localparam int STATES = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        tbl_we, tbl_commit, busy, err;
  logic [2:0]  tbl_addr, tbl_next, err_code;
  logic [7:0]  tbl_mask, tbl_value;

  fsm_table_loader dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .tbl_we(tbl_we),
    .tbl_addr(tbl_addr), .tbl_mask(tbl_mask), .tbl_value(tbl_value),
    .tbl_next(tbl_next), .tbl_commit(tbl_commit), .busy(busy), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 write, 1 commit, 2 err; lat is cycles after the final word's accept
  typedef struct {
    int         kind;
    logic [2:0] addr;
    logic [7:0] mask;
    logic [7:0] value;
    logic [2:0] nxt;
    logic [2:0] code;
    int         lat;
  } ev_t;

  ev_t         exp_q[$];
  logic [32:0] img[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          last_acc = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic push_ev(input int k, input logic [2:0] a, input logic [7:0] m,
                         input logic [7:0] v, input logic [2:0] nx,
                         input logic [2:0] c, input int lat);
    ev_t e;
    e.kind = k; e.addr = a; e.mask = m; e.value = v; e.nxt = nx; e.code = c; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Image-level interpretation of the stream rules. Every image ends at its
  // first last-marked word, so error latency is measured from that accept.
  task automatic model();
    logic [31:0] h, w0, w1, w2;
    int n, idx;
    h = img[0][31:0];
    n = int'(h[15:0]);
    if (h[31:24] != 8'hA5) begin push_ev(2, 0, 0, 0, 0, 3'd1, 0); return; end
    if (n == 0 || n > STATES) begin push_ev(2, 0, 0, 0, 0, 3'd2, 0); return; end
    if (img[0][32]) begin push_ev(2, 0, 0, 0, 0, 3'd5, 0); return; end
    idx = 1;
    for (int e = 0; e < n; e++) begin
      w0 = img[idx][31:0];
      if (img[idx][32]) begin push_ev(2, 0, 0, 0, 0, 3'd5, 0); return; end
      w1 = img[idx+1][31:0];
      if (img[idx+1][32]) begin push_ev(2, 0, 0, 0, 0, 3'd5, 0); return; end
      w2 = img[idx+2][31:0];
      if ((w2[7:0] & ~w1[7:0]) != 8'h00) begin push_ev(2, 0, 0, 0, 0, 3'd4, 0); return; end
      push_ev(0, w0[2:0], w1[7:0], w2[7:0], w0[18:16], 0, 0);
      if (img[idx+2][32]) begin
        if (e < n - 1) push_ev(2, 0, 0, 0, 0, 3'd5, 1);
        else           push_ev(1, 0, 0, 0, 0, 0, 1);
        return;
      end
      if (e == n - 1) begin push_ev(2, 0, 0, 0, 0, 3'd6, 0); return; end
      idx += 3;
    end
  endtask

  task automatic add(input logic [31:0] d, input logic l);
    img.push_back({l, d});
  endtask

  // kind 0 bad magic, 1 bad count, 2 value outside mask, 3 early last,
  // 4 missing last, otherwise a clean image
  task automatic gen(input int kind);
    logic [31:0] w;
    logic [7:0]  m, v;
    int n, k, b, idx, junk;
    img.delete();
    n = $urandom_range(1, STATES);
    if (kind == 1) n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(STATES + 1, 300);
    w = $urandom;
    w[31:24] = 8'hA5;
    if (kind == 0) while (w[31:24] == 8'hA5) w[31:24] = 8'($urandom);
    w[15:0] = 16'(n);
    add(w, 1'b0);
    if (kind <= 1) begin
      junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) add($urandom, 1'b0);
      img[img.size()-1][32] = 1'b1;
      return;
    end
    k = $urandom_range(0, n - 1);
    for (int e = 0; e < n; e++) begin
      add($urandom, 1'b0);
      m = 8'($urandom);
      v = 8'($urandom) & m;
      if (kind == 2 && e == k) begin
        b = $urandom_range(0, 7);
        m[b] = 1'b0;
        v[b] = 1'b1;
      end
      w = $urandom; w[7:0] = m; add(w, 1'b0);
      w = $urandom; w[7:0] = v; add(w, 1'b0);
    end
    if (kind == 4) begin
      junk = $urandom_range(1, 3);
      for (int j = 0; j < junk; j++) add($urandom, 1'b0);
    end
    img[img.size()-1][32] = 1'b1;
    if (kind == 3) begin
      idx = 1 + 3 * k + $urandom_range(0, 1);
      img[idx][32] = 1'b1;
      while (img.size() > idx + 1) void'(img.pop_back());
    end
  endtask

  task automatic send(input logic [32:0] word, input bit gap);
    int n;
    if (gap) begin
      cfg_valid = 1'b0;
      @(posedge clk); #1;
    end
    cfg_data  = word[31:0];
    cfg_last  = word[32];
    cfg_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: cfg_ready stayed 0, expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    if (word[32]) last_acc = cyc;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic run_image(input bit gap);
    int n;
    model();
    foreach (img[i]) send(img[i], gap);
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("events_outstanding", exp_q.size(), 0);
    chk("idle_after_image", busy, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    ev_t e;
    int  k;
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          chk("ready_pattern", cfg_ready, !(tbl_we || tbl_commit || err));
          if (tbl_we || tbl_commit || err) begin
            k = tbl_we ? 0 : (tbl_commit ? 1 : 2);
            if (exp_q.size() == 0) begin
              vectors++; miscompares++;
              $display("FAIL unexpected_event: got kind %0d code %0d, expected no event", k, err_code);
            end else begin
              e = exp_q.pop_front();
              chk("event_kind", k, e.kind);
              if (k == e.kind) begin
                if (k == 0) begin
                  chk("tbl_addr", tbl_addr, e.addr);
                  chk("tbl_mask", tbl_mask, e.mask);
                  chk("tbl_value", tbl_value, e.value);
                  chk("tbl_next", tbl_next, e.nxt);
                end else if (k == 1) begin
                  chk("commit_latency", cyc - last_acc, e.lat);
                end else begin
                  chk("err_code", err_code, e.code);
                  chk("err_latency", cyc - last_acc, e.lat);
                end
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {tbl_we, tbl_commit, err, err_code, tbl_addr, tbl_next, tbl_mask, tbl_value}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", cfg_ready, 1'b1);

    // happy path, contiguous then with cfg_valid toggling
    for (int g = 0; g < 2; g++) begin
      img.delete();
      add(32'hA500_0002, 0); add(32'h0003_0000, 0); add(32'h0000_000F, 0); add(32'h0000_0005, 0);
      add(32'h0000_0003, 0); add(32'h0000_0080, 0); add(32'h0000_0080, 1);
      run_image(g == 1);
    end

    // count above STATES, three words drained
    img.delete();
    add(32'hA500_0009, 0); add(32'h1234_5678, 0); add(32'h9ABC_DEF0, 0); add(32'h0000_0001, 1);
    run_image(0);

    // value outside mask in entry 1, drained to the end of entry 2
    img.delete();
    add(32'hA500_0002, 0); add(32'h0001_0002, 0); add(32'h0000_000F, 0); add(32'h0000_0010, 0);
    add(32'h0004_0005, 0); add(32'h0000_00FF, 0); add(32'h0000_0011, 1);
    run_image(0);

    // last on the first W2 of a two-entry image
    img.delete();
    add(32'hA500_0002, 0); add(32'h0002_0001, 0); add(32'h0000_0033, 0); add(32'h0000_0021, 1);
    run_image(0);

    // reset while waiting for the mask of entry 1 of 2
    img.delete();
    send({1'b0, 32'hA500_0002}, 0);
    send({1'b0, 32'h0003_0000}, 0);
    chk("pre_abort_busy", busy, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", cfg_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_outs", {tbl_we, tbl_commit, err, err_code, tbl_addr, tbl_next, tbl_mask, tbl_value}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    img.delete();
    add(32'hA500_0001, 0); add(32'h0005_0006, 0); add(32'h0000_00FF, 0); add(32'h0000_003C, 1);
    run_image(0);

    for (int t = 0; t < 60; t++) begin
      gen($urandom_range(0, 9));
      run_image($urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fsm_table_loader.md
Name: fsm_table_loader

Overview:
- Writer side of the transition-table interface consumed by fsm: receives a table image over a valid/ready word stream, checks it, and writes transition entries into the fsm staging table.
- Signals `tbl_commit` only after a complete, error-free image, so the fsm bank swap is atomic.
- Sits between the host/CSR bridge and the fsm instance.

Parameters:
- INPUTS, 8, width of the fsm input vector; also the width of each mask/value.
- STATES, 8, number of fsm states, which is also the number of table entries.
- STWIDTH, $clog2(STATES), state index width.
- DATA_W, 32, stream word width; must be >= max(INPUTS, 16+STWIDTH) and >= 32.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `cfg_valid`  in  1  stream word valid.
- `cfg_ready`  out  1  stream word accepted when valid&ready.
- `cfg_data`  in  DATA_W  stream word.
- `cfg_last`  in  1  marks the final word of an image.
- `tbl_we`  out  1  staging-table write strobe.
- `tbl_addr`  out  STWIDTH  source state being written.
- `tbl_mask`  out  INPUTS  input care-mask of the entry.
- `tbl_value`  out  INPUTS  required input value under the mask.
- `tbl_next`  out  STWIDTH  next state on match.
- `tbl_commit`  out  1  one-cycle pulse: swap the staging table in.
- `busy`  out  1  image in progress (any state other than HDR).
- `err`  out  1  one-cycle pulse: image rejected.
- `err_code`  out  3  reason; valid with `err`, held until the next `err`.

Behaviour:
- Reset: synchronous, active-low, when `rst`=0 at a `clk` edge. Takes effect at the next edge from any state.
  - State→HDR; `cfg_ready`=0 during reset, 1 afterwards.
  - `tbl_we`, `tbl_commit`, `err`, `busy`=0; `err_code`=0; `tbl_addr/mask/value/next`=0; entry counter=0.
  - An interrupted image never commits; staging content is don't-care.
- Stream format:
  - Header: [31:24]=8'hA5 magic, [15:0]=entry count N.
  - Then N entries of 3 words each:
    - W0: [STWIDTH-1:0]=src, [16+STWIDTH-1:16]=next.
    - W1: mask in [INPUTS-1:0].
    - W2: value in [INPUTS-1:0].
  - Unused upper bits are ignored.
  - `cfg_last` is required on the final W2 and on no other word.
- States: HDR, ADDR, MASK, VALUE, WRITE, COMMIT, DRAIN, ERR.
  - HDR: `cfg_ready`=1. On accept:
    - magic≠A5 → code 1.
    - N=0 or N>STATES → code 2.
    - else store N → ADDR.
  - ADDR: on accept, src≥STATES or next≥STATES → code 3; else latch → MASK.
  - MASK: on accept, latch mask → VALUE.
  - VALUE: on accept:
    - value & ~mask ≠ 0 → code 4.
    - else latch value → WRITE.
  - WRITE: `cfg_ready`=0; `tbl_we`=1 for exactly one cycle with the latched fields; counter+1.
    - Counter==N and last was seen on W2 → COMMIT.
    - Counter==N and no last → code 6.
    - Counter<N and last was seen → code 5.
    - Otherwise → ADDR.
  - Any accepted word in ADDR/MASK with `cfg_last`=1 → code 5.
  - COMMIT: `tbl_commit`=1 for one cycle → HDR.
- Error entry:
  - If the offending word carried `cfg_last`, or last was already consumed → ERR.
  - Otherwise → DRAIN.
- DRAIN: `cfg_ready`=1, discards words until `cfg_last` is accepted → ERR.
- ERR: `err`=1 for one cycle with `err_code` → HDR. No commit.
- Latency:
  - Last word accepted → `tbl_commit` exactly 2 cycles later (WRITE, COMMIT).
  - Error detected on a last-marked word → `err` the next cycle.
- Throughput: 3 words per entry plus 1 bubble cycle per entry (WRITE state).
- Duplicate src addresses are allowed; the later entry overwrites the earlier one. Entries not written keep their previous staging content.
- `cfg_valid`=0 in any state holds the state indefinitely; there is no timeout.

Decomposition:
- Shared package fsm_pkg holds:
  - CFG_MAGIC=8'hA5.
  - Error-code enum: NONE=0, BAD_MAGIC=1, BAD_COUNT=2, BAD_INDEX=3, VALUE_OUTSIDE_MASK=4, EARLY_LAST=5, MISSING_LAST=6.
  - Loader state enum.
  - Field offsets for W0 (src at 0, next at 16).
- No sub-module: one FSM plus a datapath latch block.

Test Plan:
- Happy path, STATES=8, INPUTS=8: header A5000002.
  - Entries: (src0, next3, mask 0F, value 05); (src3, next0, mask 80, value 80); last on the 2nd W2.
  - Required: two `tbl_we` pulses with exactly those fields, `tbl_commit` 2 cycles after the last accept, `err` never asserts.
- Header A5000009 (N>STATES) followed by 3 more words, last on the 3rd.
  - Required: no `tbl_we`, all 3 words drained with `cfg_ready`=1, then `err`=1 with code 2, no commit.
- Entry with mask 0F, value 10.
  - Required: code 4 after drain, no `tbl_we` for that entry, no commit.
- N=2 but `cfg_last` on the 1st entry's W2.
  - Required: `tbl_we` once, then `err` code 5 on the next cycle, no commit.
- `rst`=0 asserted during MASK of entry 1 of 2, then a fresh valid N=1 image.
  - Required: no commit from the aborted image, outputs zero during reset, the new image commits normally.
- Backpressure/idle check: `cfg_valid` toggled every other cycle over the happy-path image.
  - Required: identical writes and commit; `cfg_ready` low only in WRITE/COMMIT/ERR cycles.
